tlk2711_reg_bridge: RTL and testbench

- AXI4-Lite slave that drives the TLK2711 register bus (write strobe/address/data, read strobe/address) and returns the bus read data to the PS.
- Sits between the PS AXI-Lite master port and the dual-channel TLK2711 block. The bus read data it samples is the OR of the A and B channel read data.
- Single clock domain on the PS clock; performs no CDC.

---
 rtl/tlk2711_pkg.sv | 26 ++
 rtl/tlk2711_reg_bridge.sv | 276 +++++++++++++++++++++++++++
 tb/tb_tlk2711_reg_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlk2711_pkg.sv
// ---------------------------------------------------------------------------
// tlk2711_pkg
// Shared definitions for the TLK2711 register bridge: AXI response codes,
// the write/read FSM state encodings and the default register bus width.
// ---------------------------------------------------------------------------
package tlk2711_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEF_REG_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ISSUE,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } rd_state_t;

endpackage

// File: rtl/tlk2711_reg_bridge.sv
// ---------------------------------------------------------------------------
// tlk2711_reg_bridge
// AXI4-Lite slave that turns PS register accesses into single-cycle strobes
// on the TLK2711 register bus and returns the sampled bus read data.
//
// Ports:
//   ps_clk, ps_rst          clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*        AXI-Lite write address, data and response
//   s_axil_ar*/r*           AXI-Lite read address and data
//   o_reg_wen/waddr/wdata   register write strobe, address, data
//   o_reg_ren/raddr         register read strobe, address
//   i_reg_rdata             register read data (A and B channels OR'd)
//
// The write and read FSMs are independent. Every output is driven from a
// register or decoded from registered state only, so no strobe can glitch.
// ---------------------------------------------------------------------------
module tlk2711_reg_bridge
    import tlk2711_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int REG_DATA_WIDTH = 64,
    parameter int ADDR_SHIFT     = 3,
    parameter int RD_LATENCY     = 1
) (
    input  logic                        ps_clk,
    input  logic                        ps_rst,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,
    input  logic [REG_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [REG_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,
    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,
    output logic [REG_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,
    output logic                        o_reg_wen,
    output logic [REG_ADDR_WIDTH-1:0]   o_reg_waddr,
    output logic [REG_DATA_WIDTH-1:0]   o_reg_wdata,
    output logic                        o_reg_ren,
    output logic [REG_ADDR_WIDTH-1:0]   o_reg_raddr,
    input  logic [REG_DATA_WIDTH-1:0]   i_reg_rdata
);

    localparam int STRB_WIDTH = REG_DATA_WIDTH / 8;

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    wr_state_t                   wrState_q,  wrState_d;
    logic                        awHeld_q,   awHeld_d;
    logic                        wHeld_q,    wHeld_d;
    logic [AXI_ADDR_WIDTH-1:0]   awAddr_q,   awAddr_d;
    logic [REG_DATA_WIDTH-1:0]   wData_q,    wData_d;
    logic [STRB_WIDTH-1:0]       wStrb_q,    wStrb_d;
    logic                        regWen_q,   regWen_d;
    logic [REG_ADDR_WIDTH-1:0]   regWaddr_q, regWaddr_d;
    logic [REG_DATA_WIDTH-1:0]   regWdata_q, regWdata_d;
    logic                        bvalid_q,   bvalid_d;
    logic [1:0]                  bresp_q,    bresp_d;

    logic                        awFire;
    logic                        wFire;
    logic [AXI_ADDR_WIDTH-1:0]   awAddrEff;
    logic [REG_DATA_WIDTH-1:0]   wDataEff;
    logic [STRB_WIDTH-1:0]       wStrbEff;
    logic                        wrLegal;

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    rd_state_t                   rdState_q,  rdState_d;
    logic                        rdBad_q,    rdBad_d;
    logic [2:0]                  rdCnt_q,    rdCnt_d;
    logic                        regRen_q,   regRen_d;
    logic [REG_ADDR_WIDTH-1:0]   regRaddr_q, regRaddr_d;
    logic                        rvalid_q,   rvalid_d;
    logic [REG_DATA_WIDTH-1:0]   rdata_q,    rdata_d;
    logic [1:0]                  rresp_q,    rresp_d;

    // Readies are decoded from registered state only: awready/wready drop
    // once their half of the write is held and come back after the response.
    assign s_axil_awready = (wrState_q == WR_IDLE) && !awHeld_q;
    assign s_axil_wready  = (wrState_q == WR_IDLE) && !wHeld_q;
    assign s_axil_arready = (rdState_q == RD_IDLE);

    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign o_reg_wen      = regWen_q;
    assign o_reg_waddr    = regWaddr_q;
    assign o_reg_wdata    = regWdata_q;
    assign o_reg_ren      = regRen_q;
    assign o_reg_raddr    = regRaddr_q;

    assign awFire    = s_axil_awvalid && s_axil_awready;
    assign wFire     = s_axil_wvalid && s_axil_wready;
    // Whichever half arrives last is taken straight from the bus so the
    // ISSUE-cycle outputs can be registered on the completing handshake.
    assign awAddrEff = awHeld_q ? awAddr_q : s_axil_awaddr;
    assign wDataEff  = wHeld_q ? wData_q : s_axil_wdata;
    assign wStrbEff  = wHeld_q ? wStrb_q : s_axil_wstrb;
    assign wrLegal   = (awAddrEff[ADDR_SHIFT-1:0] == '0) && (&wStrbEff);

    // Write FSM: collect AW and W in either order, pulse the register write
    // strobe for one cycle (legal accesses only), then hold the response.
    always_comb begin
        wrState_d  = wrState_q;
        awHeld_d   = awHeld_q;
        wHeld_d    = wHeld_q;
        awAddr_d   = awAddr_q;
        wData_d    = wData_q;
        wStrb_d    = wStrb_q;
        regWen_d   = 1'b0;
        regWaddr_d = regWaddr_q;
        regWdata_d = regWdata_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        case (wrState_q)
            WR_IDLE: begin
                if (awFire) begin
                    awHeld_d = 1'b1;
                    awAddr_d = s_axil_awaddr;
                end
                if (wFire) begin
                    wHeld_d = 1'b1;
                    wData_d = s_axil_wdata;
                    wStrb_d = s_axil_wstrb;
                end
                if ((awHeld_q || awFire) && (wHeld_q || wFire)) begin
                    wrState_d = WR_ISSUE;
                    if (wrLegal) begin
                        regWen_d   = 1'b1;
                        regWaddr_d = REG_ADDR_WIDTH'(awAddrEff >> ADDR_SHIFT);
                        regWdata_d = wDataEff;
                        bresp_d    = RESP_OKAY;
                    end else begin
                        bresp_d    = RESP_SLVERR;
                    end
                end
            end
            WR_ISSUE: begin
                wrState_d = WR_RESP;
                bvalid_d  = 1'b1;
            end
            WR_RESP: begin
                if (s_axil_bready) begin
                    wrState_d = WR_IDLE;
                    bvalid_d  = 1'b0;
                    awHeld_d  = 1'b0;
                    wHeld_d   = 1'b0;
                end
            end
            default: begin
                wrState_d = WR_IDLE;
            end
        endcase
    end

    // Read FSM: latch the request, pulse the read strobe, wait RD_LATENCY
    // cycles for the bus data, then hold the response until accepted.
    always_comb begin
        rdState_d  = rdState_q;
        rdBad_d    = rdBad_q;
        rdCnt_d    = rdCnt_q;
        regRen_d   = 1'b0;
        regRaddr_d = regRaddr_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rdState_q)
            RD_IDLE: begin
                if (s_axil_arvalid) begin
                    rdState_d = RD_ISSUE;
                    rdBad_d   = (s_axil_araddr[ADDR_SHIFT-1:0] != '0);
                    if (s_axil_araddr[ADDR_SHIFT-1:0] == '0) begin
                        regRen_d   = 1'b1;
                        regRaddr_d = REG_ADDR_WIDTH'(s_axil_araddr >> ADDR_SHIFT);
                    end
                end
            end
            RD_ISSUE: begin
                if (rdBad_q) begin
                    rdState_d = RD_RESP;
                    rdata_d   = '0;
                    rresp_d   = RESP_SLVERR;
                    rvalid_d  = 1'b1;
                end else if (RD_LATENCY == 0) begin
                    rdState_d = RD_RESP;
                    rdata_d   = i_reg_rdata;
                    rresp_d   = RESP_OKAY;
                    rvalid_d  = 1'b1;
                end else begin
                    rdState_d = RD_WAIT;
                    rdCnt_d   = 3'd1;
                end
            end
            RD_WAIT: begin
                // The counter names the cycle after the strobe, starting at 1.
                if (rdCnt_q == 3'(RD_LATENCY)) begin
                    rdState_d = RD_RESP;
                    rdata_d   = i_reg_rdata;
                    rresp_d   = RESP_OKAY;
                    rvalid_d  = 1'b1;
                end else begin
                    rdCnt_d   = rdCnt_q + 3'd1;
                end
            end
            RD_RESP: begin
                if (s_axil_rready) begin
                    rdState_d = RD_IDLE;
                    rvalid_d  = 1'b0;
                end
            end
            default: begin
                rdState_d = RD_IDLE;
            end
        endcase
    end

    // State registers for both directions; reset discards any held request.
    always_ff @(posedge ps_clk or negedge ps_rst) begin
        if (!ps_rst) begin
            wrState_q  <= WR_IDLE;
            awHeld_q   <= 1'b0;
            wHeld_q    <= 1'b0;
            awAddr_q   <= '0;
            wData_q    <= '0;
            wStrb_q    <= '0;
            regWen_q   <= 1'b0;
            regWaddr_q <= '0;
            regWdata_q <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rdState_q  <= RD_IDLE;
            rdBad_q    <= 1'b0;
            rdCnt_q    <= 3'd0;
            regRen_q   <= 1'b0;
            regRaddr_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wrState_q  <= wrState_d;
            awHeld_q   <= awHeld_d;
            wHeld_q    <= wHeld_d;
            awAddr_q   <= awAddr_d;
            wData_q    <= wData_d;
            wStrb_q    <= wStrb_d;
            regWen_q   <= regWen_d;
            regWaddr_q <= regWaddr_d;
            regWdata_q <= regWdata_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rdState_q  <= rdState_d;
            rdBad_q    <= rdBad_d;
            rdCnt_q    <= rdCnt_d;
            regRen_q   <= regRen_d;
            regRaddr_q <= regRaddr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_tlk2711_reg_bridge.sv
// ---------------------------------------------------------------------------
// tb_tlk2711_reg_bridge
// Three bridge instances (read latency 0, 1 and 3) share one AXI-Lite
// stimulus. A behavioural register bus holds 256 registers written by the
// latency-1 instance's strobes; each instance gets read data from its own
// latency-matched pipeline that only carries data in the expected cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tlk2711_reg_bridge;

    logic        ps_clk = 1'b0;
    logic        ps_rst;
    logic [31:0] s_axil_awaddr;
    logic        s_axil_awvalid;
    logic [63:0] s_axil_wdata;
    logic [7:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_bready;
    logic [31:0] s_axil_araddr;
    logic        s_axil_arvalid;
    logic        s_axil_rready;

    logic        awreadyV [3];
    logic        wreadyV  [3];
    logic        bvalidV  [3];
    logic [1:0]  brespV   [3];
    logic        arreadyV [3];
    logic        rvalidV  [3];
    logic [1:0]  rrespV   [3];
    logic [63:0] rdataV   [3];
    logic        wenV     [3];
    logic [15:0] waddrV   [3];
    logic [63:0] wdataV   [3];
    logic        renV     [3];
    logic [15:0] raddrV   [3];

    logic [63:0] mem    [256];
    logic [63:0] refMem [256];
    logic [63:0] modelRd0;
    logic [63:0] modelRd1;
    logic [63:0] modelRd3;
    logic [63:0] pipe1;
    logic [63:0] pipe2;

    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          wenCount = 0;
    int          renCount = 0;
    int          wenCycle = 0;
    int          renCycle = 0;
    logic [15:0] lastWaddr;
    logic [63:0] lastWdata;
    logic [15:0] lastRaddr;
    logic [1:0]  gotBresp;
    logic [1:0]  gotRresp [3];
    logic [63:0] gotRdata [3];

    always #5 ps_clk = ~ps_clk;

    // One bridge per read latency under test; all see identical AXI inputs.
    for (genvar g = 0; g < 3; g++) begin : gDut
        tlk2711_reg_bridge #(
            .RD_LATENCY(g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) uDut (
            .ps_clk        (ps_clk),
            .ps_rst        (ps_rst),
            .s_axil_awaddr (s_axil_awaddr),
            .s_axil_awvalid(s_axil_awvalid),
            .s_axil_awready(awreadyV[g]),
            .s_axil_wdata  (s_axil_wdata),
            .s_axil_wstrb  (s_axil_wstrb),
            .s_axil_wvalid (s_axil_wvalid),
            .s_axil_wready (wreadyV[g]),
            .s_axil_bresp  (brespV[g]),
            .s_axil_bvalid (bvalidV[g]),
            .s_axil_bready (s_axil_bready),
            .s_axil_araddr (s_axil_araddr),
            .s_axil_arvalid(s_axil_arvalid),
            .s_axil_arready(arreadyV[g]),
            .s_axil_rdata  (rdataV[g]),
            .s_axil_rresp  (rrespV[g]),
            .s_axil_rvalid (rvalidV[g]),
            .s_axil_rready (s_axil_rready),
            .o_reg_wen     (wenV[g]),
            .o_reg_waddr   (waddrV[g]),
            .o_reg_wdata   (wdataV[g]),
            .o_reg_ren     (renV[g]),
            .o_reg_raddr   (raddrV[g]),
            .i_reg_rdata   (g == 0 ? modelRd0 : (g == 1 ? modelRd1 : modelRd3))
        );
    end

    // Register bus read models: data is present only in the cycle the
    // bridge should sample it, zero otherwise.
    assign modelRd0 = renV[0] ? mem[raddrV[0][7:0]] : 64'd0;

    always @(posedge ps_clk) begin
        modelRd1 <= renV[1] ? mem[raddrV[1][7:0]] : 64'd0;
    end

    always @(posedge ps_clk) begin
        pipe1    <= renV[2] ? mem[raddrV[2][7:0]] : 64'd0;
        pipe2    <= pipe1;
        modelRd3 <= pipe2;
    end

    // Single comparison point: counts, asserts and reports.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock; sample #1 after the edge, log strobes, update the
    // register bus and watch for dropped valids and unknown outputs.
    task automatic tick();
        logic bvPre;
        logic brPre;
        logic rvPre;
        logic rrPre;
        bvPre = bvalidV[1];
        brPre = s_axil_bready;
        rvPre = rvalidV[1];
        rrPre = s_axil_rready;
        @(posedge ps_clk);
        #1;
        cycle++;
        if (wenV[1]) begin
            wenCount++;
            wenCycle  = cycle;
            lastWaddr = waddrV[1];
            lastWdata = wdataV[1];
            mem[waddrV[1][7:0]] = wdataV[1];
        end
        if (renV[1]) begin
            renCount++;
            renCycle  = cycle;
            lastRaddr = raddrV[1];
        end
        if (ps_rst && bvPre && !brPre) checkOutput("bvalidHold", 64'(bvalidV[1]), 64'd1);
        if (ps_rst && rvPre && !rrPre) checkOutput("rvalidHold", 64'(rvalidV[1]), 64'd1);
        checkOutput("xOut", 64'($isunknown({awreadyV[1], wreadyV[1], bvalidV[1], brespV[1], arreadyV[1],
                    rvalidV[1], rrespV[1], rdataV[1], wenV[1], waddrV[1], wdataV[1], renV[1], raddrV[1]})), 64'd0);
    endtask

    // Run one write and/or read. rdyD >= 0 holds bready/rready low for that
    // many valid cycles; rdyD < 0 gives random backpressure.
    task automatic applyStimulus(input bit doW, input logic [31:0] wa, input logic [63:0] wd, input logic [7:0] ws,
                                 input int awD, input int wD, input bit doR, input logic [31:0] ra,
                                 input int arD, input int rdyD);
        int cyc;
        bit awDone;
        bit wDone;
        bit bDone;
        bit arDone;
        bit rDone [3];
        int bW;
        int rW;
        cyc    = 0;
        bW     = 0;
        rW     = 0;
        awDone = !doW;
        wDone  = !doW;
        bDone  = !doW;
        arDone = !doR;
        for (int k = 0; k < 3; k++) rDone[k] = !doR;
        while (!(bDone && arDone && rDone[0] && rDone[1] && rDone[2]) && cyc < 300) begin
            s_axil_awaddr  = wa;
            s_axil_awvalid = !awDone && (cyc >= awD);
            s_axil_wdata   = wd;
            s_axil_wstrb   = ws;
            s_axil_wvalid  = !wDone && (cyc >= wD);
            s_axil_araddr  = ra;
            s_axil_arvalid = !arDone && (cyc >= arD);
            s_axil_bready  = bvalidV[1] && ((rdyD < 0) ? ($urandom_range(0, 1) == 1) : (bW >= rdyD));
            s_axil_rready  = (rdyD < 0) ? ($urandom_range(0, 1) == 1)
                           : ((rvalidV[0] || rvalidV[1] || rvalidV[2]) && (rW >= rdyD));
            if (s_axil_awvalid && awreadyV[1]) awDone = 1'b1;
            if (s_axil_wvalid && wreadyV[1]) wDone = 1'b1;
            if (s_axil_arvalid && arreadyV[1]) arDone = 1'b1;
            if (bvalidV[1] && !s_axil_bready) bW++;
            if (bvalidV[1] && s_axil_bready) begin
                bDone    = 1'b1;
                gotBresp = brespV[1];
            end
            if ((rvalidV[0] || rvalidV[1] || rvalidV[2]) && !s_axil_rready) rW++;
            for (int k = 0; k < 3; k++) begin
                if (!rDone[k] && rvalidV[k] && s_axil_rready) begin
                    rDone[k]    = 1'b1;
                    gotRdata[k] = rdataV[k];
                    gotRresp[k] = rrespV[k];
                end
            end
            cyc++;
            tick();
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_arvalid = 1'b0;
        s_axil_bready  = 1'b0;
        s_axil_rready  = 1'b0;
        checkOutput("txnDone", 64'(cyc < 300), 64'd1);
    endtask

    task automatic checkRead(input string tag, input logic [63:0] expData, input logic [1:0] expResp);
        for (int k = 0; k < 3; k++) begin
            checkOutput({tag, "Data"}, gotRdata[k], expData);
            checkOutput({tag, "Resp"}, 64'(gotRresp[k]), 64'(expResp));
        end
    endtask

    initial begin
        logic [7:0]  idx;
        logic [63:0] data;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 64'd0;
            refMem[i] = 64'd0;
        end
        ps_rst         = 1'b0;
        s_axil_awaddr  = '0;
        s_axil_awvalid = 1'b0;
        s_axil_wdata   = '0;
        s_axil_wstrb   = '0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b0;
        s_axil_araddr  = '0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;
        tick();
        tick();
        // Reset state: readies high, everything else low.
        for (int k = 0; k < 3; k++) begin
            checkOutput("resetState", 64'({awreadyV[k], wreadyV[k], arreadyV[k], bvalidV[k], rvalidV[k],
                        wenV[k], renV[k], brespV[k], rrespV[k]}), 64'b111_0000_0000);
        end
        ps_rst = 1'b1;
        tick();

        // AW first, W two cycles later, bready held off for 5 cycles.
        wenCount = 0;
        applyStimulus(1, 32'h0808, 64'h1122334455667788, 8'hFF, 0, 2, 0, 32'h0, 0, 5);
        checkOutput("wr1WenCount", 64'(wenCount), 64'd1);
        checkOutput("wr1Waddr", 64'(lastWaddr), 64'h0101);
        checkOutput("wr1Wdata", lastWdata, 64'h1122334455667788);
        checkOutput("wr1Bresp", 64'(gotBresp), 64'd0);
        refMem[8'h01] = 64'h1122334455667788;

        // W before AW, misaligned address.
        wenCount = 0;
        applyStimulus(1, 32'h0004, 64'hAAAA5555AAAA5555, 8'hFF, 2, 0, 0, 32'h0, 0, 0);
        checkOutput("wrMisWen", 64'(wenCount), 64'd0);
        checkOutput("wrMisBresp", 64'(gotBresp), 64'd2);

        // Partial strobes are refused.
        applyStimulus(1, 32'h0020, 64'hBBBB5555BBBB5555, 8'h0F, 0, 0, 0, 32'h0, 0, 1);
        checkOutput("wrStrbWen", 64'(wenCount), 64'd0);
        checkOutput("wrStrbBresp", 64'(gotBresp), 64'd2);

        // Load register 2, then read it back through all three latencies.
        applyStimulus(1, 32'h0010, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, 0, 0, 32'h0, 0, 0);
        refMem[8'h02] = 64'hDEADBEEFCAFEF00D;
        renCount = 0;
        applyStimulus(0, 32'h0, 64'h0, 8'h0, 0, 0, 1, 32'h0010, 0, 1);
        checkOutput("rdRenCount", 64'(renCount), 64'd1);
        checkOutput("rdRaddr", 64'(lastRaddr), 64'h0002);
        checkRead("rdLat", 64'hDEADBEEFCAFEF00D, 2'b00);

        // Misaligned read: no strobe, zero data, SLVERR.
        renCount = 0;
        applyStimulus(0, 32'h0, 64'h0, 8'h0, 0, 0, 1, 32'h0012, 0, 0);
        checkOutput("rdMisRen", 64'(renCount), 64'd0);
        checkRead("rdMis", 64'd0, 2'b10);

        // Write and read launched together under random backpressure.
        wenCount = 0;
        renCount = 0;
        applyStimulus(1, 32'h0028, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 1, 32'h0010, 0, -1);
        refMem[8'h05] = 64'h0123456789ABCDEF;
        checkOutput("simulWen", 64'(wenCount), 64'd1);
        checkOutput("simulRen", 64'(renCount), 64'd1);
        checkOutput("simulSameCycle", 64'(wenCycle), 64'(renCycle));
        checkOutput("simulBresp", 64'(gotBresp), 64'd0);
        checkRead("simul", 64'hDEADBEEFCAFEF00D, 2'b00);

        // Reset while the write waits in WR_RESP and reads are still waiting.
        s_axil_awaddr  = 32'h0018;
        s_axil_wdata   = 64'h5A5A5A5A00000003;
        s_axil_wstrb   = 8'hFF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        s_axil_araddr  = 32'h0010;
        s_axil_arvalid = 1'b1;
        tick();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_arvalid = 1'b0;
        tick();
        refMem[8'h03] = 64'h5A5A5A5A00000003;
        checkOutput("preRstBvalid", 64'(bvalidV[1]), 64'd1);
        checkOutput("preRstRvalid", 64'(rvalidV[2]), 64'd0);
        #2 ps_rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("midRstState", 64'({awreadyV[k], wreadyV[k], arreadyV[k], bvalidV[k], rvalidV[k],
                        wenV[k], renV[k]}), 64'b111_0000);
        end
        wenCount = 0;
        renCount = 0;
        tick();
        tick();
        ps_rst = 1'b1;
        tick();
        tick();
        tick();
        tick();
        checkOutput("postRstWen", 64'(wenCount), 64'd0);
        checkOutput("postRstRen", 64'(renCount), 64'd0);
        checkOutput("postRstRvalid", 64'(rvalidV[2]), 64'd0);
        applyStimulus(1, 32'h0030, 64'hFEEDFACE00000006, 8'hFF, 1, 0, 1, 32'h0018, 0, 0);
        refMem[8'h06] = 64'hFEEDFACE00000006;
        checkOutput("postRstBresp", 64'(gotBresp), 64'd0);
        checkOutput("postRstWaddr", 64'(lastWaddr), 64'h0006);
        checkRead("postRst", 64'h5A5A5A5A00000003, 2'b00);

        // Random aligned writes followed by random reads against refMem.
        for (int n = 0; n < 100; n++) begin
            idx  = 8'($urandom_range(0, 31));
            data = {$urandom, $urandom};
            applyStimulus(1, {21'd0, idx, 3'b000}, data, 8'hFF, $urandom_range(0, 2), $urandom_range(0, 2),
                          0, 32'h0, 0, $urandom_range(0, 1));
            refMem[idx] = data;
        end
        for (int n = 0; n < 100; n++) begin
            idx = 8'($urandom_range(0, 31));
            applyStimulus(0, 32'h0, 64'h0, 8'h0, 0, 0, 1, {21'd0, idx, 3'b000}, $urandom_range(0, 2), -1);
            checkRead("randRd", refMem[idx], 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
